// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Owns the PC and keeps at most one word fetch outstanding on a req/ack memory port.
// Feeds the IF/ID register and inserts NOP bubbles when no instruction is ready.
// A one-entry skid buffer catches a fetch that completes while downstream is stalled.
// A branch redirect forces a bubble. A fetch still in flight on the wrong path is
// allowed to finish and its data is thrown away.
module if_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic                mem_req_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [ADDR_W-1:0]   if_pc_reg;
    logic [INST_W-1:0]   if_inst_reg;
    logic                if_valid_reg;
    logic                skid_valid_reg;
    logic [ADDR_W-1:0]   skid_pc_reg;
    logic [INST_W-1:0]   skid_inst_reg;
    logic                kill_reg;

    logic [ADDR_W-1:0]   pc_inc;
    logic                take;

    // Sequential PC; wraps silently at the top of the address space.
    assign pc_inc = pc_reg + ADDR_W'(4);

    // A response is usable only in FETCH and only if the fetch was not made on a
    // path that has since been redirected away from.
    assign take = mem_ack && (state_reg == S_FETCH) && !kill_reg;

    // Fetch FSM. It also owns the skid buffer and the registered IF/ID outputs.
    // A branch overrides stall and every other event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= RESET_PC;
            if_pc_reg      <= '0;
            if_inst_reg    <= NOP_INST;
            if_valid_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_inst_reg  <= NOP_INST;
            kill_reg       <= 1'b0;
        end else if (br) begin
            pc_reg         <= br_addr;
            if_inst_reg    <= NOP_INST;
            if_valid_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            mem_req_reg    <= 1'b1;
            if (((state_reg == S_FETCH) || (state_reg == S_KILL)) && !mem_ack) begin
                // A request cannot be withdrawn. Keep it up on the stale address
                // and drop its data when it returns.
                state_reg <= S_KILL;
                kill_reg  <= 1'b1;
            end else begin
                state_reg    <= S_FETCH;
                kill_reg     <= 1'b0;
                mem_addr_reg <= br_addr;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg    <= S_FETCH;
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= pc_reg;
                    if (!stall) begin
                        if_inst_reg  <= NOP_INST;
                        if_valid_reg <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (take) begin
                        pc_reg <= pc_inc;
                        if (stall) begin
                            // Downstream is full, so park the word. No new request
                            // is issued until the skid entry drains.
                            skid_pc_reg    <= mem_addr_reg;
                            skid_inst_reg  <= mem_rdata;
                            skid_valid_reg <= 1'b1;
                            state_reg      <= S_DRAIN;
                            mem_req_reg    <= 1'b0;
                        end else begin
                            if_pc_reg    <= mem_addr_reg;
                            if_inst_reg  <= mem_rdata;
                            if_valid_reg <= 1'b1;
                            mem_addr_reg <= pc_inc;
                        end
                    end else if (!stall) begin
                        if_inst_reg  <= NOP_INST;
                        if_valid_reg <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!stall && skid_valid_reg) begin
                        if_pc_reg      <= skid_pc_reg;
                        if_inst_reg    <= skid_inst_reg;
                        if_valid_reg   <= 1'b1;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= S_FETCH;
                        mem_req_reg    <= 1'b1;
                        mem_addr_reg   <= pc_reg;
                    end
                end
                S_KILL: begin
                    if (mem_ack) begin
                        kill_reg     <= 1'b0;
                        state_reg    <= S_FETCH;
                        mem_addr_reg <= pc_reg;
                    end
                    if (!stall) begin
                        if_inst_reg  <= NOP_INST;
                        if_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign if_pc    = if_pc_reg;
    assign if_inst  = if_inst_reg;
    assign if_valid = if_valid_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch.
// The memory returns a fixed hash of each address. The reference model is a
// transaction scoreboard: valid instructions must leave in program order, starting
// at RESET_PC, stepping by 4, and restarting at each branch target. Outputs must
// hold under stall and must be bubbles on the edge of a branch. The request must
// stay up, at a stable address, until it is acknowledged.
module tb_if_fetch;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk;
    logic        rst;
    logic        br;
    logic [31:0] br_addr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_ret    = 0;
    int          lat      = 0;
    int          wc       = 0;
    bit          mem_rand = 1'b0;
    bit          sb_en    = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] held;
    logic [31:0] pend;
    int          ret_before;

    if_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .br        (br),
        .br_addr   (br_addr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_valid  (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish (observed running, expected done)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: apply the current inputs, score the result, then drive the
    // memory response for the next edge.
    task automatic tick();
        logic [31:0] o_pc, o_inst, o_addr, a_baddr;
        logic        o_v, o_req, o_ack, a_br, a_stall;
        o_pc    = if_pc;
        o_inst  = if_inst;
        o_v     = if_valid;
        o_req   = mem_req;
        o_addr  = mem_addr;
        o_ack   = mem_ack;
        a_br    = br;
        a_stall = stall;
        a_baddr = br_addr;
        @(posedge clk);
        #1;
        br = 1'b0;
        if (sb_en) begin
            if (o_req && !o_ack) begin
                chk1("req_hold", mem_req, 1'b1);
                chk("addr_hold", mem_addr, o_addr);
            end
            if (a_br) begin
                chk1("br_bubble_v", if_valid, 1'b0);
                chk("br_bubble_inst", if_inst, NOP);
                chk("br_pc_hold", if_pc, o_pc);
                exp_pc = a_baddr;
            end else if (a_stall) begin
                chk("stall_pc", if_pc, o_pc);
                chk("stall_inst", if_inst, o_inst);
                chk1("stall_v", if_valid, o_v);
            end else if (if_valid) begin
                chk("seq_pc", if_pc, exp_pc);
                chk("seq_inst", if_inst, inst_of(exp_pc));
                $display("retire pc=%h inst=%h", if_pc, if_inst);
                n_ret++;
                exp_pc = exp_pc + 32'd4;
            end else begin
                chk("bubble_inst", if_inst, NOP);
                chk("bubble_pc", if_pc, o_pc);
            end
        end
        if (o_ack || !mem_req) wc = 0;
        if (mem_req) begin
            if (mem_rand) mem_ack = ($urandom_range(0, 2) == 0);
            else          mem_ack = (wc >= lat);
            if (!mem_ack) wc++;
        end else begin
            mem_ack = 1'b0;
        end
        mem_rdata = mem_ack ? inst_of(mem_addr) : $urandom();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !if_valid; i++) tick();
        chk1(tag, if_valid, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        br        = 1'b0;
        br_addr   = '0;
        stall     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_pc    = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset values
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 32'd0);
        sb_en = 1'b1;

        // Zero-latency memory gives one instruction per cycle
        lat = 0;
        tick();
        chk1("first_req", mem_req, 1'b1);
        chk("first_addr", mem_addr, RESET_PC);
        chk1("first_bubble", if_valid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1("stream_v", if_valid, 1'b1);
            chk("stream_pc", if_pc, RESET_PC + 32'(4 * k));
            chk("stream_addr", mem_addr, RESET_PC + 32'(4 * (k + 1)));
        end

        // Slow memory: two bubbles between instructions, address stable while waiting
        lat = 2;
        tick();
        chk("slow_first_pc", if_pc, 32'd24);
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                chk1("slow_bubble_v", if_valid, 1'b0);
                chk("slow_bubble_inst", if_inst, NOP);
                chk("slow_addr", mem_addr, 32'd28 + 32'(4 * r));
            end
            tick();
            chk1("slow_v", if_valid, 1'b1);
            chk("slow_pc", if_pc, 32'd28 + 32'(4 * r));
        end

        // Stall while a fetch is outstanding: it completes into the skid buffer
        held  = if_pc;
        stall = 1'b1;
        for (int i = 0; i < 20 && mem_req; i++) tick();
        chk1("drain_req", mem_req, 1'b0);
        chk("drain_hold_pc", if_pc, held);
        chk1("drain_hold_v", if_valid, 1'b1);
        tick();
        chk1("drain_req2", mem_req, 1'b0);
        stall = 1'b0;
        tick();
        chk("skid_out_pc", if_pc, held + 32'd4);
        chk1("skid_out_v", if_valid, 1'b1);
        chk1("refetch_req", mem_req, 1'b1);
        chk("refetch_addr", mem_addr, held + 32'd8);

        // Branch while a fetch is pending: the stale response must be discarded
        lat     = 6;
        pend    = mem_addr;
        br      = 1'b1;
        br_addr = 32'h00000100;
        tick();
        chk1("kill_req", mem_req, 1'b1);
        chk("kill_addr", mem_addr, pend);
        for (int i = 0; i < 20 && mem_addr == pend; i++) begin
            tick();
            chk1("kill_bubble", if_valid, 1'b0);
        end
        chk("redirect_addr", mem_addr, 32'h00000100);
        lat = 0;
        wait_valid("redirect_to", 20);
        chk("redirect_pc", if_pc, 32'h00000100);

        // Branch while stalled with the skid buffer full
        stall = 1'b1;
        for (int i = 0; i < 20 && mem_req; i++) tick();
        chk1("skid_full", mem_req, 1'b0);
        br      = 1'b1;
        br_addr = 32'h00000200;
        tick();
        chk1("brstall_v", if_valid, 1'b0);
        chk1("brstall_req", mem_req, 1'b1);
        chk("brstall_addr", mem_addr, 32'h00000200);
        stall = 1'b0;
        wait_valid("brstall_to", 20);
        chk("brstall_pc", if_pc, 32'h00000200);

        // PC wraps at the top of the address space
        br      = 1'b1;
        br_addr = 32'hFFFFFFF8;
        tick();
        for (int i = 0; i < 10 && !(if_valid && if_pc == 32'd0); i++) tick();
        chk("wrap_pc", if_pc, 32'd0);

        // Asynchronous reset between edges while a fetch is outstanding
        lat = 3;
        tick();
        tick();
        chk1("pre_rst_req", mem_req, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk1("arst_req", mem_req, 1'b0);
        chk1("arst_valid", if_valid, 1'b0);
        chk("arst_inst", if_inst, NOP);
        sb_en   = 1'b0;
        mem_ack = 1'b0;
        wc      = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // A stray ack in IDLE must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        chk1("stray_req", mem_req, 1'b1);
        chk("stray_addr", mem_addr, RESET_PC);
        chk1("stray_valid", if_valid, 1'b0);
        mem_ack = 1'b0;
        wc      = 0;
        lat     = 0;
        exp_pc  = RESET_PC;
        sb_en   = 1'b1;
        wait_valid("post_rst_to", 20);
        chk("post_rst_pc", if_pc, RESET_PC);

        // Randomized traffic: random ack timing, stalls and redirects
        mem_rand   = 1'b1;
        ret_before = n_ret;
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                br = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    br_addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                else
                    br_addr = $urandom() & 32'hFFFFFFFC;
            end
            tick();
        end
        stall    = 1'b0;
        mem_rand = 1'b0;
        lat      = 0;
        repeat (5) tick();
        chk1("random_progress", (n_ret - ret_before) > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
